// File: rtl/bus_pkg.sv
// ============================================================================
//  Module   : bus_pkg
//  Brief    : Shared packet type and destination helpers for the bus agents.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

  localparam int          PKT_W        = 16;
  localparam int          DEST_W       = 8;
  localparam logic [7:0]  BROADCAST_ID = 8'hFF;

  typedef logic [PKT_W-1:0] pckt_t;

  // Destination id lives in the top byte of every packet.
  function automatic logic [DEST_W-1:0] dest_of(input pckt_t p);
    return p[PKT_W-1 -: DEST_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_fifo_mem.sv
// ============================================================================
//  Module   : bus_fifo_mem
//  Brief    : DEPTH x W register array, one write port, asynchronous read port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 48,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  // Storage is deliberately not reset; readers gate the output by occupancy.
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/bus_dev_tx_fifo.sv
// ============================================================================
//  Module   : bus_dev_tx_fifo
//  Brief    : Per-device transmit FIFO with enqueue timestamps, feeding the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_dev_tx_fifo
  import bus_pkg::*;
#(
  parameter int         PCKG_SZ = 16,
  parameter int         DEPTH   = 8,
  parameter int         TS_W    = 32,
  parameter logic [7:0] DEV_ID  = 8'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [PCKG_SZ-1:0]         D_push,
  output logic                       full,
  output logic                       pndng,
  input  logic                       pop,
  output logic [PCKG_SZ-1:0]         D_pop,
  output logic [TS_W-1:0]            ts_pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                ovf_cnt,
  output logic                       self_dest
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             CW       = AW + 1;
  localparam int             EW       = PCKG_SZ + TS_W;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       ovf_q, ovf_d;
  logic [TS_W-1:0]   cyc_q;
  logic              full_q, pndng_q;

  logic              pop_eff;
  logic              push_ok;
  logic              mem_we;
  logic [EW-1:0]     head;
  logic [PCKG_SZ-1:0] head_pkt;

  always_comb begin
    pop_eff = pop && pndng_q;
    // A pop on the same edge frees the slot a full-FIFO push needs.
    push_ok = push && (!full_q || pop_eff);
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push_ok) begin
      wr_d = wr_q + 1'b1;
    end
    if (pop_eff) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push_ok, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push && !push_ok && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= '0;
      cyc_q   <= '0;
      full_q  <= 1'b0;
      pndng_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_q + 1'b1;
      full_q  <= (count_d == FULL_CNT);
      pndng_q <= (count_d != '0);
    end
  end

  assign mem_we = push_ok && reset;

  bus_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_q[AW-1:0]),
    .wdata_i ({D_push, cyc_q}),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (head)
  );

  assign head_pkt  = head[EW-1 -: PCKG_SZ];
  assign D_pop     = pndng_q ? head_pkt : '0;
  assign ts_pop    = pndng_q ? head[TS_W-1:0] : '0;
  assign self_dest = pndng_q && (head_pkt[PCKG_SZ-1 -: DEST_W] == DEV_ID);
  assign full      = full_q;
  assign pndng     = pndng_q;
  assign count     = count_q;
  assign ovf_cnt   = ovf_q;

  // The wrap-bit pointer distance must always agree with the occupancy count.
  a_ptr_count: assert property (@(posedge clk) disable iff (!reset)
                                (wr_q - rd_q) == count_q);

endmodule

`default_nettype wire

// File: tb/tb_bus_dev_tx_fifo.sv
// ============================================================================
//  Module   : tb_bus_dev_tx_fifo
//  Brief    : Randomized scoreboard bench for bus_dev_tx_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_dev_tx_fifo;
  import bus_pkg::*;

  localparam int         PCKG_SZ = 16;
  localparam int         DEPTH   = 8;
  localparam int         TS_W    = 32;
  localparam logic [7:0] DEV_ID  = 8'd3;

  logic               clk;
  logic               reset;
  logic               push;
  logic [PCKG_SZ-1:0] D_push;
  logic               full;
  logic               pndng;
  logic               pop;
  logic [PCKG_SZ-1:0] D_pop;
  logic [TS_W-1:0]    ts_pop;
  logic [3:0]         count;
  logic [15:0]        ovf_cnt;
  logic               self_dest;

  bus_dev_tx_fifo #(
    .PCKG_SZ (PCKG_SZ),
    .DEPTH   (DEPTH),
    .TS_W    (TS_W),
    .DEV_ID  (DEV_ID)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .D_push    (D_push),
    .full      (full),
    .pndng     (pndng),
    .pop       (pop),
    .D_pop     (D_pop),
    .ts_pop    (ts_pop),
    .count     (count),
    .ovf_cnt   (ovf_cnt),
    .self_dest (self_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pkt;
    logic [31:0] ts;
  } ent_t;

  ent_t        sb_q[$];
  logic [31:0] m_cyc;
  int unsigned m_ovf;
  int          total;
  int          bad;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {packet, stamp} plus a cycle tally.
  always @(posedge clk) begin
    if (!reset) begin
      sb_q.delete();
      m_cyc = 0;
      m_ovf = 0;
    end else begin
      automatic bit was_full = (sb_q.size() == DEPTH);
      automatic bit took     = pop && (sb_q.size() > 0);
      ent_t e;
      if (took) void'(sb_q.pop_front());
      if (push) begin
        if (!was_full || took) begin
          e.pkt = D_push;
          e.ts  = m_cyc;
          sb_q.push_back(e);
        end else if (m_ovf < 65535) begin
          m_ovf++;
        end
      end
      m_cyc = m_cyc + 1;
    end
  end

  // Monitor: compares everything the DUT presents mid-cycle against the model.
  always @(negedge clk) begin
    chk("count", 64'(count), 64'(sb_q.size()));
    chk("full", 64'(full), 64'(sb_q.size() == DEPTH));
    chk("pndng", 64'(pndng), 64'(sb_q.size() != 0));
    chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
    if (sb_q.size() > 0) begin
      chk("D_pop", 64'(D_pop), 64'(sb_q[0].pkt));
      chk("ts_pop", 64'(ts_pop), 64'(sb_q[0].ts));
      chk("self_dest", 64'(self_dest), 64'(sb_q[0].pkt[15:8] == DEV_ID));
    end else begin
      chk("D_pop_empty", 64'(D_pop), 64'd0);
      chk("ts_pop_empty", 64'(ts_pop), 64'd0);
      chk("self_dest_empty", 64'(self_dest), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [15:0] d);
    push   = 1'b1;
    D_push = d;
    tick();
    push   = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b0;
    push   = 1'b1;
    pop    = 1'b0;
    D_push = 16'hBEEF;
    tick();
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pndng", 64'(pndng), 64'd0);
    reset = 1'b1;
    push  = 1'b0;

    // Ten idle edges stamp 0..9, so the push edge carries stamp 10.
    repeat (10) tick();
    do_push(16'h0355);
    chk("first_pkt", 64'(D_pop), 64'h0355);
    chk("first_ts", 64'(ts_pop), 64'd10);
    chk("first_dest", 64'(dest_of(D_pop)), 64'd3);
    chk("first_self", 64'(self_dest), 64'd1);
    pop = 1'b1;
    tick();
    pop = 1'b0;

    for (int i = 0; i < DEPTH; i++) do_push(16'h0100 + 16'(i));
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd8);
    do_push(16'hDEAD);
    chk("drop_ovf", 64'(ovf_cnt), 64'd1);
    chk("drop_head", 64'(D_pop), 64'h0100);

    push   = 1'b1;
    pop    = 1'b1;
    D_push = 16'h0777;
    tick();
    push   = 1'b0;
    chk("swap_count", 64'(count), 64'd8);
    chk("swap_ovf", 64'(ovf_cnt), 64'd1);
    repeat (DEPTH) tick();
    pop = 1'b0;
    chk("drained", 64'(pndng), 64'd0);

    pop = 1'b1;
    repeat (3) tick();
    pop = 1'b0;
    chk("empty_pop_count", 64'(count), 64'd0);
    do_push(16'h0211);
    do_push(16'h0322);
    chk("after_empty_head", 64'(D_pop), 64'h0211);
    pop = 1'b1;
    repeat (2) tick();
    pop = 1'b0;

    for (int i = 0; i < 5; i++) do_push(16'h0A00 + 16'(i));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_pndng", 64'(pndng), 64'd0);
    do_push(16'h04AA);
    chk("post_rst_head", 64'(D_pop), 64'h04AA);

    // Randomized phases sweep push/pop pressure; an occasional reset is mixed in.
    for (int ph = 0; ph < 4; ph++) begin
      automatic int pp = (ph % 2 == 0) ? 80 : 30;
      automatic int qp = (ph % 2 == 0) ? 30 : 80;
      for (int c = 0; c < 150; c++) begin
        push   = ($urandom_range(99) < pp);
        pop    = ($urandom_range(99) < qp);
        D_push = {8'($urandom_range(7)), 8'($urandom)};
        reset  = ($urandom_range(199) != 0);
        tick();
      end
    end
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
